// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if
//   Bundles the requester side (valid/ready request, one-hot response strobe,
//   shared result bus) and the shared fpu side (start/op/A/B out, ready/C in)
//   of the arbiter.
//   slave  : the arbiter's view (drives req_ready, resp_*, busy, fpu_start/op/a/b).
//   master : the environment's view (drives req_*, fpu_ready, fpu_c).
interface fpu_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_op;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      resp_valid;
    logic [31:0]          resp_data;
    logic                 resp_err;
    logic                 busy;
    logic                 fpu_start;
    logic                 fpu_op;
    logic [31:0]          fpu_a;
    logic [31:0]          fpu_b;
    logic                 fpu_ready;
    logic [31:0]          fpu_c;

    modport slave (
        input  req_valid, req_op, req_a, req_b, fpu_ready, fpu_c,
        output req_ready, resp_valid, resp_data, resp_err, busy,
               fpu_start, fpu_op, fpu_a, fpu_b
    );

    modport master (
        output req_valid, req_op, req_a, req_b, fpu_ready, fpu_c,
        input  req_ready, resp_valid, resp_data, resp_err, busy,
               fpu_start, fpu_op, fpu_a, fpu_b
    );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter
//   Round-robin sharing of one fpu among NREQ requesters. One operation is in
//   flight at a time; operands are latched at accept and held until the
//   response. The fpu start/ready handshake is sequenced through
//   ISSUE -> WAIT_LO -> WAIT_HI, each wait guarded by a TMO-cycle watchdog that
//   answers with a quiet NaN and resp_err when the fpu does not respond.
// Ports
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : fpu_arb_if.slave (request/response and fpu signals)
module fpu_arbiter #(
    parameter int NREQ = 4,
    parameter int TMO  = 32
) (
    input  logic     clk,
    input  logic     rst,
    fpu_arb_if.slave bus
);
    localparam int          IW   = $clog2(NREQ);
    localparam int          CW   = $clog2(TMO) + 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP} state_t;

    state_t          state_q;
    logic [IW-1:0]   last_q;        // last winner; also the current owner
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] resp_valid_q;
    logic [31:0]     resp_data_q;
    logic            resp_err_q;
    logic            fpu_op_q;
    logic [31:0]     fpu_a_q;
    logic [31:0]     fpu_b_q;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   idx;
    logic            sel_op;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [NREQ-1:0] owner_oh;

    // Search starts one past the last winner and wraps, so a requester that
    // just got served has the lowest priority on the next round.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_q) + k) % NREQ);
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
        sel_op   = 1'b0;
        sel_a    = '0;
        sel_b    = '0;
        owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == win_idx) begin
                sel_op = bus.req_op[i];
                sel_a  = bus.req_a[32*i +: 32];
                sel_b  = bus.req_b[32*i +: 32];
            end
            if (IW'(i) == last_q) owner_oh[i] = 1'b1;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (!rst && state_q == IDLE && win_found) bus.req_ready[win_idx] = 1'b1;
    end

    // Start only while the fpu reports idle, so a start is never lost.
    assign bus.fpu_start  = (state_q == ISSUE) && bus.fpu_ready;
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.fpu_op     = fpu_op_q;
    assign bus.fpu_a      = fpu_a_q;
    assign bus.fpu_b      = fpu_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= IW'(NREQ - 1);
            cnt_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            fpu_op_q     <= 1'b0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
        end else begin
            resp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        fpu_op_q <= sel_op;
                        fpu_a_q  <= sel_a;
                        fpu_b_q  <= sel_b;
                        last_q   <= win_idx;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.fpu_ready) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_LO;
                    end
                end
                // Ready must drop first, otherwise a stale high ready would be
                // mistaken for completion.
                WAIT_LO: begin
                    if (!bus.fpu_ready) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_HI;
                    end else if (cnt_q == CW'(TMO - 1)) begin
                        resp_data_q  <= QNAN;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= owner_oh;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (bus.fpu_ready) begin
                        resp_data_q  <= bus.fpu_c;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= owner_oh;
                        state_q      <= RESP;
                    end else if (cnt_q == CW'(TMO - 1)) begin
                        resp_data_q  <= QNAN;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= owner_oh;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one fpu instance (start/op/A/B in, ready/C out) among NREQ requesters using round-robin arbitration.
- Per requester: a valid/ready request handshake and a one-cycle response strobe with a shared result bus.
- Holds operands stable for the whole fpu operation.
- Sequences the fpu start/ready handshake and guards it with a watchdog.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TMO, 32, watchdog limit in cycles for each fpu wait state.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-hot accept; high only in the accept cycle.
- req_op  in  NREQ  op per requester (0 add, 1 sub).
- req_a  in  32*NREQ  flattened A operands; requester i uses [32i+31:32i].
- req_b  in  32*NREQ  flattened B operands, same packing as req_a.
- resp_valid  out  NREQ  one-hot, one-cycle result strobe.
- resp_data  out  32  result; valid while resp_valid != 0.
- resp_err  out  1  watchdog expiry flag; valid with resp_valid.
- busy  out  1  high whenever state != IDLE.
- fpu_start  out  1  to fpu start.
- fpu_op  out  1  to fpu op.
- fpu_a  out  32  to fpu A.
- fpu_b  out  32  to fpu B.
- fpu_ready  in  1  from fpu ready.
- fpu_c  in  32  from fpu C.

Behaviour:
- Reset values: state IDLE; req_ready 0; resp_valid 0; resp_data 0; resp_err 0; fpu_start 0; fpu_op/a/b 0; rr pointer last = NREQ-1, so requester 0 wins first; watchdog counter 0.
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP.
- IDLE:
  - Winner g is the first set bit of req_valid, searching from last+1 and wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle.
  - At the edge: latch req_op/a/b of g into the fpu_op/fpu_a/fpu_b registers; last<=g; go to ISSUE.
  - No req_valid set: stay in IDLE.
- ISSUE:
  - fpu_start=1 only while fpu_ready=1. Then go to WAIT_LO and clear the counter.
  - fpu_ready=0: hold in ISSUE without start.
- WAIT_LO: wait for fpu_ready=0, which confirms the fpu has left its idle state. Then go to WAIT_HI and clear the counter.
- WAIT_HI: wait for fpu_ready=1. Then capture fpu_c into resp_data, resp_err<=0, go to RESP.
- Watchdog, both wait states:
  - Counter increments each cycle in the state.
  - When it reaches TMO-1 without the awaited level: resp_data<=32'h7FC00000 (qNaN), resp_err<=1, go to RESP.
- RESP: resp_valid[g]=1 for exactly one cycle, then IDLE. resp_data and resp_err hold until the next RESP.
- Operand stability: fpu_op/fpu_a/fpu_b are registers, written only on IDLE accept, and constant from ISSUE through RESP.
- Ordering: exactly one operation in flight. Requests arriving while busy wait, and req_valid must stay high until req_ready.
- Nominal latency with the standard fpu:
  - Accept at cycle t; fpu_start at t+1; WAIT_LO sees ready low at t+2.
  - fpu_ready returns at t+7; resp_valid at t+8; next accept possible at t+9.
  - Throughput is one op per 9 cycles.
- Simultaneous events:
  - A winner's req_valid dropping in the accept cycle is illegal.
  - A requester may re-assert req_valid in its own RESP cycle; it is considered at the next IDLE under round-robin order.
- Reset mid-operation: all state is cleared immediately. No resp_valid is issued for the aborted operation; the requester re-requests.
- fpu_start is never asserted outside ISSUE.

Test Plan:
- Req0: op=0, A=32'h3F800000, B=32'h40000000 -> req_ready[0] at t, fpu_start at t+1, resp_valid[0] at t+8, resp_data=32'h40400000, resp_err=0.
- Req1: op=1, A=32'h40A00000, B=32'h40400000 -> resp_valid[1], resp_data=32'h40000000. fpu_a/fpu_b stay constant from ISSUE to RESP.
- Req0, req2 and req3 all asserted in the same cycle after reset -> grants in order 0, 2, 3. Each gets its own correct sum; no resp overlaps.
- Requester 1 held permanently valid while requester 3 asserts -> grants alternate 1, 3, 1, 3. Neither requester starves.
- fpu stub holds fpu_ready=1 forever -> after TMO cycles in WAIT_LO: resp_valid, resp_err=1, resp_data=32'h7FC00000, then IDLE.
- rst pulsed during WAIT_HI -> all outputs at reset values next cycle; no resp_valid; a fresh request completes normally.
